// File: rtl/pci_target_ctrl_pkg.sv
// pci_pkg: command codes, FSM state encoding and default word-index width for the PCI target.
package pci_pkg;
  localparam int ADDR_W_DEF = 5;
  localparam logic [3:0] CMD_RD = 4'b0110;
  localparam logic [3:0] CMD_WR = 4'b0111;
  typedef enum logic [2:0] {S_IDLE, S_BUSY, S_RD_TURN, S_DATA, S_DISC} state_t;
endpackage

// File: rtl/pci_target_ctrl_par_gen.sv
// pci_par_gen: registered even parity over AD/CBE# plus a one-clock-delayed output enable.
module pci_par_gen (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [31:0] ad,
  input  logic [3:0]  cbe_n,
  input  logic        oe,
  output logic        par,
  output logic        par_oe
);
  logic par_q, par_d, par_oe_q, par_oe_d;
  always_comb begin
    par_d = en ? ^{ad, cbe_n} : par_q;
    par_oe_d = oe;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      par_q <= 1'b0;
      par_oe_q <= 1'b0;
    end else begin
      par_q <= par_d;
      par_oe_q <= par_oe_d;
    end
  end
  assign par = par_q;
  assign par_oe = par_oe_q;
endmodule

// File: rtl/pci_target_ctrl.sv
// pci_target_ctrl: PCI target sequencer claiming memory read/write bursts into a local word memory.
// Define PCI_TGT_PARITY_EN to add the PAR/PAR_oe read-parity outputs.
module pci_target_ctrl
  import pci_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              FRAME_n,
  input  logic              IRDY_n,
  input  logic [3:0]        CBE_n,
  input  logic [31:0]       AD_in,
  input  logic              dec_valid,
  input  logic [ADDR_W-1:0] dec_local,
  output logic [31:0]       AD_out,
  output logic              AD_oe,
  output logic              DEVSEL_n,
  output logic              TRDY_n,
  output logic              STOP_n,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  output logic              mem_we,
  input  logic [31:0]       mem_rdata
`ifdef PCI_TGT_PARITY_EN
  ,
  output logic              PAR,
  output logic              PAR_oe
`endif
);
  localparam logic [ADDR_W-1:0] LAST = '1;
  state_t state_q, state_d;
  logic rd_q, rd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic devsel_n_q, devsel_n_d, trdy_n_q, trdy_n_d, stop_n_q, stop_n_d, ad_oe_q, ad_oe_d;
  logic claim, xfer;
  // Bus outputs are derived from the next state so they are registered alongside it.
  always_comb begin
    claim = !FRAME_n && dec_valid && (CBE_n == CMD_RD || CBE_n == CMD_WR);
    xfer = state_q == S_DATA && !IRDY_n && !trdy_n_q;
    state_d = state_q;
    rd_d = rd_q;
    addr_d = addr_q;
    case (state_q)
      S_IDLE:
        if (claim) begin
          state_d = CBE_n == CMD_RD ? S_RD_TURN : S_DATA;
          rd_d = CBE_n == CMD_RD;
          addr_d = dec_local;
        end else if (!FRAME_n) state_d = S_BUSY;
      S_BUSY:    if (FRAME_n && IRDY_n) state_d = S_IDLE;
      S_RD_TURN: state_d = S_DATA;
      S_DATA:
        if (xfer) begin
          state_d = FRAME_n ? S_IDLE : addr_q == LAST ? S_DISC : S_DATA;
          addr_d = addr_q == LAST ? addr_q : addr_q + ADDR_W'(1);
        end
      S_DISC:    if (FRAME_n) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    devsel_n_d = state_d == S_IDLE || state_d == S_BUSY;
    trdy_n_d = state_d != S_DATA;
    stop_n_d = !(state_d == S_DISC || (state_d == S_DATA && addr_d == LAST));
    ad_oe_d = rd_d && (state_d == S_RD_TURN || state_d == S_DATA);
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      rd_q <= 1'b0;
      addr_q <= '0;
      devsel_n_q <= 1'b1;
      trdy_n_q <= 1'b1;
      stop_n_q <= 1'b1;
      ad_oe_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_q <= rd_d;
      addr_q <= addr_d;
      devsel_n_q <= devsel_n_d;
      trdy_n_q <= trdy_n_d;
      stop_n_q <= stop_n_d;
      ad_oe_q <= ad_oe_d;
    end
  end
  assign DEVSEL_n = devsel_n_q;
  assign TRDY_n = trdy_n_q;
  assign STOP_n = stop_n_q;
  assign AD_oe = ad_oe_q;
  assign AD_out = ad_oe_q ? mem_rdata : 32'h0;
  assign mem_addr = addr_q;
  assign mem_wdata = AD_in;
  assign mem_be = ~CBE_n;
  // A write coinciding with reset is dropped so reset cleanly abandons the burst.
  assign mem_we = xfer && !rd_q && !RST;
`ifdef PCI_TGT_PARITY_EN
  pci_par_gen u_par (
    .clk(CLK), .rst(RST), .en(state_q == S_DATA && rd_q), .ad(AD_out), .cbe_n(CBE_n),
    .oe(ad_oe_q), .par(PAR), .par_oe(PAR_oe)
  );
`endif
endmodule

// File: tb/tb_pci_target_ctrl.sv
// tb_pci_target_ctrl: directed and randomized PCI target bursts checked against a word-memory model.
module tb_pci_target_ctrl;
  import pci_pkg::*;
  logic        CLK = 1'b0, RST = 1'b1, FRAME_n = 1'b1, IRDY_n = 1'b1, dec_valid = 1'b0;
  logic [3:0]  CBE_n = 4'hF;
  logic [31:0] AD_in = 32'h0;
  logic [4:0]  dec_local = 5'd0;
  logic [31:0] AD_out, mem_wdata, mem_rdata;
  logic        AD_oe, DEVSEL_n, TRDY_n, STOP_n, mem_we;
  logic [4:0]  mem_addr;
  logic [3:0]  mem_be;
`ifdef PCI_TGT_PARITY_EN
  logic        PAR, PAR_oe;
`endif
  logic [31:0] tb_mem [32];
  logic [31:0] ref_mem [32];
  int n_cmp = 0, n_bad = 0;

  pci_target_ctrl dut (
    .CLK(CLK), .RST(RST), .FRAME_n(FRAME_n), .IRDY_n(IRDY_n), .CBE_n(CBE_n), .AD_in(AD_in),
    .dec_valid(dec_valid), .dec_local(dec_local), .AD_out(AD_out), .AD_oe(AD_oe),
    .DEVSEL_n(DEVSEL_n), .TRDY_n(TRDY_n), .STOP_n(STOP_n), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_we(mem_we), .mem_rdata(mem_rdata)
`ifdef PCI_TGT_PARITY_EN
    , .PAR(PAR), .PAR_oe(PAR_oe)
`endif
  );

  always #5 CLK = ~CLK;
  assign mem_rdata = tb_mem[mem_addr];
  always @(posedge CLK)
    if (mem_we)
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) tb_mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus(input string tag, input logic dev, input logic trdy, input logic stop,
                     input logic oe, input logic we);
    chk({tag, ".devsel_n"}, 32'(DEVSEL_n), 32'(dev));
    chk({tag, ".trdy_n"}, 32'(TRDY_n), 32'(trdy));
    chk({tag, ".stop_n"}, 32'(STOP_n), 32'(stop));
    chk({tag, ".ad_oe"}, 32'(AD_oe), 32'(oe));
    chk({tag, ".mem_we"}, 32'(mem_we), 32'(we));
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input string tag);
    int bad;
    FRAME_n = 1'b1; IRDY_n = 1'b1; dec_valid = 1'b0; CBE_n = 4'($urandom);
    #1;
    bus(tag, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk({tag, ".ad_out"}, AD_out, 32'h0);
    bad = 0;
    for (int i = 0; i < 32; i++) if (tb_mem[i] !== ref_mem[i]) bad++;
    chk({tag, ".mem_image_diffs"}, 32'(bad), 32'h0);
    tick();
  endtask

  // Master-side burst: n transfers from start, wait states before transfer wait_at (plus random
  // ones unless fix). Memory beyond index 31 is unreachable: the target disconnects after 31.
  task automatic txn(input logic wr, input int start, input int n, input int wait_at,
                     input int wait_len, input logic fix, input logic [31:0] d0);
    int addr, waits, done;
    logic last, disc;
    logic [3:0] be;
    logic [31:0] wd;
    FRAME_n = 1'b0; IRDY_n = 1'b1; CBE_n = wr ? CMD_WR : CMD_RD;
    dec_valid = 1'b1; dec_local = 5'(start); AD_in = $urandom;
    tick();
    dec_valid = 1'($urandom); dec_local = 5'($urandom);
    addr = start; disc = 1'b0; done = 0;
    if (!wr) begin
      FRAME_n = 1'b0; IRDY_n = 1'b1; CBE_n = 4'($urandom);
      #1;
      bus("turn", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      tick();
    end
    while (1) begin
      waits = done == wait_at ? wait_len : fix ? 0 : int'($urandom_range(0, 1));
      for (int w = 0; w < waits; w++) begin
        FRAME_n = 1'b0; IRDY_n = 1'b1; CBE_n = 4'($urandom); AD_in = $urandom;
        #1;
        bus("wait", 1'b0, 1'b0, addr != 31, !wr, 1'b0);
        chk("wait.mem_addr", 32'(mem_addr), 32'(addr));
        chk("wait.ad_out", AD_out, wr ? 32'h0 : ref_mem[addr]);
        tick();
      end
      last = done == n - 1;
      be = fix ? 4'hF : 4'($urandom);
      wd = fix ? d0 : $urandom;
      FRAME_n = last; IRDY_n = 1'b0; CBE_n = ~be; AD_in = wd;
      #1;
      bus("xfer", 1'b0, 1'b0, addr != 31, !wr, wr);
      chk("xfer.mem_addr", 32'(mem_addr), 32'(addr));
      chk("xfer.ad_out", AD_out, wr ? 32'h0 : ref_mem[addr]);
      if (wr) begin
        chk("xfer.mem_wdata", mem_wdata, wd);
        chk("xfer.mem_be", 32'(mem_be), 32'(be));
        for (int b = 0; b < 4; b++) if (be[b]) ref_mem[addr][8*b +: 8] = wd[8*b +: 8];
      end
      tick();
`ifdef PCI_TGT_PARITY_EN
      if (!wr) begin
        chk("par", 32'(PAR), 32'(^{ref_mem[addr], ~be}));
        chk("par_oe", 32'(PAR_oe), 32'h1);
      end
`endif
      done++;
      if (last) break;
      if (addr == 31) begin
        disc = 1'b1;
        break;
      end
      addr++;
    end
    if (disc) begin
      waits = int'($urandom_range(0, 2));
      for (int w = 0; w <= waits; w++) begin
        FRAME_n = 1'(w == waits); IRDY_n = 1'(w != waits);
        #1;
        bus("disc", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
      end
    end
    idle("end");
  endtask

  task automatic nclaim(input logic [3:0] cmd, input logic v, input int n);
    FRAME_n = 1'b0; IRDY_n = 1'b1; CBE_n = cmd; dec_valid = v;
    dec_local = 5'($urandom); AD_in = $urandom;
    tick();
    for (int k = 0; k < n; k++) begin
      IRDY_n = 1'b0; FRAME_n = 1'(k == n - 1); CBE_n = 4'($urandom);
      AD_in = $urandom; dec_valid = 1'($urandom);
      #1;
      bus("noclaim", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
    end
    idle("noclaim_end");
  endtask

  initial begin
    logic [3:0] c;
    for (int i = 0; i < 32; i++) begin
      tb_mem[i] = $urandom;
      ref_mem[i] = tb_mem[i];
    end
    tick();
    tick();
    bus("reset", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    RST = 1'b0;
    idle("post_reset");
    txn(1'b1, 5, 1, -1, 0, 1'b1, 32'hDEADBEEF);
    tb_mem[2] = 32'h11; tb_mem[3] = 32'h22; tb_mem[4] = 32'h33;
    ref_mem[2] = 32'h11; ref_mem[3] = 32'h22; ref_mem[4] = 32'h33;
    txn(1'b0, 2, 3, 1, 2, 1'b1, 32'h0);
    txn(1'b1, 30, 5, -1, 0, 1'b0, 32'h0);
    txn(1'b0, 31, 3, 0, 1, 1'b0, 32'h0);
    nclaim(CMD_WR, 1'b0, 3);
    nclaim(4'b0010, 1'b1, 3);
    FRAME_n = 1'b0; IRDY_n = 1'b1; CBE_n = CMD_WR; dec_valid = 1'b1; dec_local = 5'd10;
    tick();
    FRAME_n = 1'b0; IRDY_n = 1'b0; CBE_n = 4'h0; AD_in = 32'hA5A50001;
    #1;
    chk("rst_burst.we1", 32'(mem_we), 32'h1);
    ref_mem[10] = 32'hA5A50001;
    tick();
    RST = 1'b1; IRDY_n = 1'b1; AD_in = $urandom;
    #1;
    chk("rst_burst.addr", 32'(mem_addr), 32'd11);
    tick();
    RST = 1'b0;
    idle("rst_burst");
    txn(1'b1, 7, 2, -1, 0, 1'b0, 32'h0);
`ifdef PCI_TGT_PARITY_EN
    tb_mem[9] = 32'h1; ref_mem[9] = 32'h1;
    txn(1'b0, 9, 1, -1, 0, 1'b1, 32'h0);
`endif
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 4) == 0) begin
        if ($urandom_range(0, 1) == 0) nclaim($urandom_range(0, 1) == 0 ? CMD_RD : CMD_WR, 1'b0, int'($urandom_range(1, 4)));
        else begin
          c = 4'($urandom);
          if (c == CMD_RD || c == CMD_WR) c = 4'hC;
          nclaim(c, 1'b1, int'($urandom_range(1, 4)));
        end
      end else
        txn(1'($urandom), $urandom_range(0, 2) == 0 ? int'($urandom_range(27, 31)) : int'($urandom_range(0, 31)),
            int'($urandom_range(1, 6)), int'($urandom_range(0, 5)), int'($urandom_range(0, 2)), 1'b0, 32'h0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
